// File: rtl/rr_arbiter_ctrl_pkg.sv
// Shared types, defaults and index helper for the round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_N_DEFAULT        = 4;
    localparam int ARB_MAX_HOLD_DEFAULT = 8;

    // Next requester index in the circular scan order, wrapping n-1 -> 0.
    function automatic int arb_next_idx(input int idx, input int n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter_ctrl_pick.sv
// Combinational rotating-priority picker: first set request bit scanning
// upward from (last+1) mod N, wrapping through N-1 to 0. Holds no state.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int N   = ARB_N_DEFAULT,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [IDW-1:0] win_id,
    output logic           any
);

    int             idx_s;
    logic [IDW-1:0] idx_v_s;
    logic           hit_s;

    // Walk all N positions after last; the first requesting one wins.
    always_comb begin
        win_id  = '0;
        any     = 1'b0;
        idx_s   = int'(last);
        idx_v_s = last;
        hit_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_s   = arb_next_idx(idx_s, N);
            idx_v_s = IDW'(idx_s);
            hit_s   = req[idx_v_s] & ~any;
            win_id  = hit_s ? idx_v_s : win_id;
            any     = any | hit_s;
        end
    end

endmodule

// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter: grants one requester at a time, holds the grant until
// release or a hold-time limit, and inserts one idle bubble between grants.
module rr_arbiter_ctrl
    import arb_pkg::*;
#(
    parameter  int N        = ARB_N_DEFAULT,
    parameter  int MAX_HOLD = ARB_MAX_HOLD_DEFAULT,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rstN,
    input  logic [N-1:0]   req,
    input  logic           release_i,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout
);

    localparam int HCW = $clog2(MAX_HOLD + 1);

    arb_state_t     state_r;
    arb_state_t     state_nxt_s;
    logic [HCW-1:0] hold_cnt_r;
    logic [HCW-1:0] hold_cnt_nxt_s;
    logic [IDW-1:0] last_r;
    logic [IDW-1:0] last_nxt_s;
    logic [N-1:0]   gnt_r;
    logic [N-1:0]   gnt_nxt_s;
    logic [IDW-1:0] gnt_id_r;
    logic [IDW-1:0] gnt_id_nxt_s;
    logic           gnt_valid_r;
    logic           timeout_r;
    logic           timeout_nxt_s;

    logic [IDW-1:0] win_id_s;
    logic           any_s;
    logic           owner_drop_s;
    logic           hold_expired_s;

    // One-hot vector with only bit id set.
    function automatic logic [N-1:0] to_onehot(input logic [IDW-1:0] id);
        return {{(N-1){1'b0}}, 1'b1} << id;
    endfunction

    rr_pick #(
        .N(N)
    ) u_pick (
        .req    (req),
        .last   (last_r),
        .win_id (win_id_s),
        .any    (any_s)
    );

    assign owner_drop_s   = release_i | ~req[gnt_id_r];
    assign hold_expired_s = (hold_cnt_r == HCW'(MAX_HOLD - 1));

    // Next-state and next-output decision; release has priority over expiry.
    always_comb begin
        state_nxt_s    = state_r;
        hold_cnt_nxt_s = hold_cnt_r;
        last_nxt_s     = last_r;
        gnt_nxt_s      = gnt_r;
        gnt_id_nxt_s   = gnt_id_r;
        timeout_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    gnt_nxt_s      = to_onehot(win_id_s);
                    gnt_id_nxt_s   = win_id_s;
                    last_nxt_s     = win_id_s;
                    hold_cnt_nxt_s = '0;
                    state_nxt_s    = GRANT;
                end else begin
                    gnt_nxt_s      = '0;
                    state_nxt_s    = IDLE;
                end
            end
            GRANT: begin
                if (owner_drop_s) begin
                    gnt_nxt_s      = '0;
                    state_nxt_s    = IDLE;
                end else if (hold_expired_s) begin
                    gnt_nxt_s      = '0;
                    timeout_nxt_s  = 1'b1;
                    state_nxt_s    = IDLE;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + HCW'(1);
                    state_nxt_s    = GRANT;
                end
            end
            default: begin
                gnt_nxt_s      = '0;
                hold_cnt_nxt_s = '0;
                state_nxt_s    = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset leaves requester 0 first.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r     <= IDLE;
            hold_cnt_r  <= '0;
            last_r      <= IDW'(N - 1);
            gnt_r       <= '0;
            gnt_id_r    <= '0;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
            last_r      <= last_nxt_s;
            gnt_r       <= gnt_nxt_s;
            gnt_id_r    <= gnt_id_nxt_s;
            gnt_valid_r <= |gnt_nxt_s;
            timeout_r   <= timeout_nxt_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_id    = gnt_id_r;
    assign gnt_valid = gnt_valid_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Self-checking bench for rr_arbiter_ctrl: directed scenarios plus random
// traffic compared every cycle against a behavioural owner/occupancy model.
module tb_rr_arbiter_ctrl;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int IDW      = 2;

    logic           clk = 1'b0;
    logic           rstN;
    logic [N-1:0]   req;
    logic           release_i;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: current owner (-1 when idle), cycles occupied so far,
    // last winner, last reported id and the timeout pulse.
    int   m_owner;
    int   m_held;
    int   m_last;
    int   m_id;
    logic m_to;

    rr_arbiter_ctrl #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .req       (req),
        .release_i (release_i),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = N - 1;
        m_id    = 0;
        m_to    = 1'b0;
    endtask

    function automatic logic [N-1:0] exp_gnt();
        return (m_owner < 0) ? '0 : (N'(1) << m_owner);
    endfunction

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    // One clock edge of the reference behaviour.
    task automatic model_step(input logic [N-1:0] r, input logic rel);
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (m_owner < 0 && bit_of(r, i)) begin
                    m_owner = i;
                    m_last  = i;
                    m_id    = i;
                    m_held  = 1;
                end
            end
        end else if (rel || !bit_of(r, m_owner)) begin
            m_owner = -1;
        end else if (m_held == MAX_HOLD) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    task automatic check_outputs();
        check_val("gnt",       32'(gnt),       32'(exp_gnt()));
        check_val("gnt_id",    32'(gnt_id),    32'(m_id));
        check_val("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check_val("timeout",   32'(timeout),   32'(m_to));
    endtask

    // Drive inputs at the falling edge, step the model at the rising edge,
    // compare at the next falling edge.
    task automatic cycle(input logic [N-1:0] r, input logic rel);
        req       = r;
        release_i = rel;
        @(posedge clk);
        model_step(r, rel);
        @(negedge clk);
        check_outputs();
    endtask

    int   ids[$];
    logic pv;
    int   cnt;
    int   to_cnt;
    int   after_to_id;
    logic seen;
    logic [N-1:0] rr;

    initial begin
        req       = '0;
        release_i = 1'b0;
        rstN      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rstN = 1'b1;

        // Alternating owners 0 and 2 with one-cycle grants and bubbles.
        pv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(4'b0101, 1'b1);
            if (gnt_valid && !pv) ids.push_back(int'(gnt_id));
            pv = gnt_valid;
        end
        check_val("t1_ngrants", 32'(ids.size()), 32'd3);
        if (ids.size() >= 3) begin
            check_val("t1_id0", 32'(ids[0]), 32'd0);
            check_val("t1_id1", 32'(ids[1]), 32'd2);
            check_val("t1_id2", 32'(ids[2]), 32'd0);
        end
        repeat (2) cycle(4'b0000, 1'b0);

        // Single requester held: MAX_HOLD cycles, timeout, regrant.
        cnt = 0; to_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle(4'b0010, 1'b0);
            if (timeout) begin
                seen = 1'b1;
                to_cnt++;
            end
            if (!seen && gnt == 4'b0010) cnt++;
        end
        check_val("t2_hold_cycles", 32'(cnt), 32'(MAX_HOLD));
        check_val("t2_timeouts", 32'(to_cnt), 32'd1);
        repeat (2) cycle(4'b0000, 1'b0);

        // Owner 3 times out while 0 waits: wrap-around to 0.
        cycle(4'b1000, 1'b0);
        seen = 1'b0; after_to_id = -1; pv = gnt_valid;
        for (int i = 0; i < 12; i++) begin
            cycle(4'b1001, 1'b0);
            if (timeout) seen = 1'b1;
            if (seen && gnt_valid && !pv && after_to_id < 0) after_to_id = int'(gnt_id);
            pv = gnt_valid;
        end
        check_val("t3_wrap_id", 32'(after_to_id), 32'd0);
        repeat (2) cycle(4'b0000, 1'b0);

        // Release coinciding with hold expiry: no timeout.
        cycle(4'b0001, 1'b0);
        repeat (MAX_HOLD - 1) cycle(4'b0001, 1'b0);
        cycle(4'b0001, 1'b1);
        check_val("t4_timeout", 32'(timeout), 32'd0);
        check_val("t4_gnt", 32'(gnt), 32'd0);
        repeat (2) cycle(4'b0000, 1'b0);

        // Owner drops its request in grant cycle 3.
        repeat (3) cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b0);
        check_val("t5_gnt", 32'(gnt), 32'd0);
        check_val("t5_timeout", 32'(timeout), 32'd0);

        // Asynchronous reset in the middle of a grant.
        repeat (3) cycle(4'b1111, 1'b0);
        #2 rstN = 1'b0;
        #1;
        check_val("t6_rst_gnt",       32'(gnt),       32'd0);
        check_val("t6_rst_gnt_valid", 32'(gnt_valid), 32'd0);
        check_val("t6_rst_gnt_id",    32'(gnt_id),    32'd0);
        check_val("t6_rst_timeout",   32'(timeout),   32'd0);
        model_reset();
        @(negedge clk);
        rstN = 1'b1;
        cycle(4'b1111, 1'b0);
        check_val("t6_first_id", 32'(gnt_id), 32'd0);
        check_val("t6_first_gnt", 32'(gnt), 32'd1);

        // Random traffic with sticky requests and occasional releases.
        rr = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 0) rr = 4'($urandom);
            cycle(rr, ($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
